// File: rtl/snake_occ_map_mp_pkg.sv
// Shared definitions for the multi-player snake occupancy map.
//   - default coordinate widths and grid size
//   - owner encoding: OWNER_EMPTY for a free cell, p+1 for player p
//   - FSM state encoding
//   - {x,y} pack/unpack helpers (x in the upper bits, y in the lower bits)
package snake_occ_map_mp_pkg;

  localparam int DEF_XW     = 6;
  localparam int DEF_YW     = 5;
  localparam int DEF_GRID_W = 40;
  localparam int DEF_GRID_H = 30;

  localparam int OWNER_EMPTY = 0;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_CHECK,
    ST_POP,
    ST_PUSH,
    ST_DONE
  } state_t;

  function automatic int owner_code(input int p);
    return p + 1;
  endfunction

  function automatic logic [DEF_XW+DEF_YW-1:0] xy_pack(input logic [DEF_XW-1:0] x,
                                                       input logic [DEF_YW-1:0] y);
    return {x, y};
  endfunction

  function automatic logic [DEF_XW-1:0] xy_x(input logic [DEF_XW+DEF_YW-1:0] xy);
    return xy[DEF_XW+DEF_YW-1:DEF_YW];
  endfunction

  function automatic logic [DEF_YW-1:0] xy_y(input logic [DEF_XW+DEF_YW-1:0] xy);
    return xy[DEF_YW-1:0];
  endfunction

endpackage

// File: rtl/snake_occ_map_mp_if.sv
// Bus between the snake game logic (master) and the occupancy map (slave).
//   master drives: clear_req, tick, ply_* player vectors, q_x/q_y draw query
//   slave drives : busy, done, hit, hit_self, tick_drop, q_owner, q_body_on
// Player p occupies slice p of every per-player vector.
interface snake_occ_map_mp_if
  import snake_occ_map_mp_pkg::*;
#(
  parameter int XW  = DEF_XW,
  parameter int YW  = DEF_YW,
  parameter int NP  = 2,
  parameter int IDW = 3
);
  logic                  clear_req;
  logic                  tick;
  logic [NP*(XW+YW)-1:0] ply_next_xy;
  logic [NP*(XW+YW)-1:0] ply_tail_xy;
  logic [NP-1:0]         ply_eat;
  logic [NP-1:0]         ply_tail_valid;
  logic [NP-1:0]         ply_alive;
  logic                  busy;
  logic                  done;
  logic [NP-1:0]         hit;
  logic [NP-1:0]         hit_self;
  logic                  tick_drop;
  logic [XW-1:0]         q_x;
  logic [YW-1:0]         q_y;
  logic [IDW-1:0]        q_owner;
  logic                  q_body_on;

  modport master (
    output clear_req, tick, ply_next_xy, ply_tail_xy, ply_eat, ply_tail_valid, ply_alive,
           q_x, q_y,
    input  busy, done, hit, hit_self, tick_drop, q_owner, q_body_on
  );

  modport slave (
    input  clear_req, tick, ply_next_xy, ply_tail_xy, ply_eat, ply_tail_valid, ply_alive,
           q_x, q_y,
    output busy, done, hit, hit_self, tick_drop, q_owner, q_body_on
  );
endinterface

// File: rtl/snake_occ_map_mp_occ_ram.sv
// Occupancy storage, one owner ID per grid cell.
//   Port A (FSM): asynchronous read, synchronous write, shared address.
//   Port B (draw query): registered read, one cycle latency.
// Contents are not reset; the map FSM clears them with its sweep.
module snake_occ_map_mp_occ_ram #(
  parameter int DEPTH = 1200,
  parameter int AW    = 11,
  parameter int IDW   = 3
)(
  input  logic           clk,
  input  logic           we_a,
  input  logic [AW-1:0]  addr_a,
  input  logic [IDW-1:0] wdata_a,
  output logic [IDW-1:0] rdata_a,
  input  logic [AW-1:0]  addr_b,
  output logic [IDW-1:0] rdata_b
);
  logic [IDW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
  end

  assign rdata_a = mem[addr_a];

  always_ff @(posedge clk) begin
    rdata_b <= mem[addr_b];
  end
endmodule

// File: rtl/snake_occ_map_mp.sv
// Multi-player grid occupancy map.
// Each game tick walks all players three times (CHECK, POP, PUSH, one player
// per cycle in ascending order) against a single-port view of the map, then
// pulses done with per-player hit / hit_self. A separate registered read port
// serves the renderer. After reset, or on clear_req, every cell is zeroed.
// Ports: clk, reset (async, active-high), bus (snake_occ_map_mp_if.slave).
// Build option: define SNAKE_HEADHEAD_EN to make two alive players whose new
// heads land on the same cell both collide (neither head is written).
// Without it both heads are written and the higher index owns the cell.
module snake_occ_map_mp
  import snake_occ_map_mp_pkg::*;
#(
  parameter int XW     = DEF_XW,
  parameter int YW     = DEF_YW,
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H,
  parameter int NP     = 2,
  parameter int IDW    = 3
)(
  input logic               clk,
  input logic               reset,
  snake_occ_map_mp_if.slave bus
);
  localparam int XYW   = XW + YW;
  localparam int CELLS = GRID_W * GRID_H;
  localparam int AW    = $clog2(CELLS);
  localparam int PW    = (NP > 1) ? $clog2(NP) : 1;

  function automatic logic in_grid(input logic [XYW-1:0] xy);
    return (int'(xy[XYW-1:YW]) < GRID_W) && (int'(xy[YW-1:0]) < GRID_H);
  endfunction

  // Off-grid coordinates map to cell 0 so the RAM is never indexed out of range.
  function automatic logic [AW-1:0] cell_addr(input logic [XYW-1:0] xy);
    if (!in_grid(xy)) return '0;
    return AW'(int'(xy[YW-1:0]) * GRID_W + int'(xy[XYW-1:YW]));
  endfunction

  function automatic logic [IDW-1:0] owner_of(input int p);
    return IDW'(owner_code(p));
  endfunction

  state_t             state, state_n;
  logic [AW-1:0]      clr_addr;
  logic [PW-1:0]      p_cnt;
  logic               clr_pend;
  logic               accept, last_p;
  logic [NP-1:0]      hit_acc, hit_self_acc;
  logic [NP-1:0]      hit_q, hit_self_q;
  logic               done_q, tick_drop_q;
  logic               q_ok_p1;

  // Tick shadow: player inputs frozen for the whole tick.
  logic [NP-1:0][XYW-1:0] sh_next, sh_tail;
  logic [NP-1:0]          sh_eat, sh_tv, sh_alive;

  logic [XYW-1:0] cur_next, cur_tail, rd_xy;
  logic [IDW-1:0] cur_own, owner_a, rd_a, rd_b;
  logic [AW-1:0]  ram_addr;
  logic           ram_we;
  logic [IDW-1:0] ram_wdata;
  logic [NP-1:0]  freed_v, hh_v;
  logic           hit_now, self_now;

  assign cur_next = sh_next[p_cnt];
  assign cur_tail = sh_tail[p_cnt];
  assign cur_own  = owner_of(int'(p_cnt));
  assign last_p   = (p_cnt == PW'(NP - 1));

  // POP looks at the tail cell; CHECK and PUSH look at the new head cell.
  assign rd_xy    = (state == ST_POP) ? cur_tail : cur_next;
  assign ram_addr = (state == ST_CLEAR) ? clr_addr : cell_addr(rd_xy);
  assign owner_a  = in_grid(rd_xy) ? rd_a : IDW'(OWNER_EMPTY);

  // A head may enter a cell that its owner vacates this same tick.
  for (genvar q = 0; q < NP; q++) begin : g_cmp
    assign freed_v[q] = sh_alive[q] && !sh_eat[q] && sh_tv[q] &&
                        (sh_tail[q] == cur_next) && (owner_a == owner_of(q));
`ifdef SNAKE_HEADHEAD_EN
    assign hh_v[q] = sh_alive[q] && (int'(p_cnt) != q) && (sh_next[q] == cur_next);
`else
    assign hh_v[q] = 1'b0;
`endif
  end

  assign accept = (state == ST_IDLE) && (state_n == ST_CHECK);

  always_comb begin
    state_n   = state;
    ram_we    = 1'b0;
    ram_wdata = IDW'(OWNER_EMPTY);
    hit_now   = 1'b0;
    self_now  = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        ram_we = 1'b1;
        if (clr_addr == AW'(CELLS - 1)) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.clear_req || clr_pend) state_n = ST_CLEAR;
        else if (bus.tick)             state_n = ST_CHECK;
      end
      ST_CHECK: begin
        hit_now  = sh_alive[p_cnt] &&
                   (!in_grid(cur_next) ||
                    ((owner_a != IDW'(OWNER_EMPTY)) && !(|freed_v)) ||
                    (|hh_v));
        self_now = hit_now && (owner_a == cur_own);
        if (last_p) state_n = ST_POP;
      end
      ST_POP: begin
        // Only clear the tail if the player still owns it (another head may have claimed it).
        ram_we = sh_alive[p_cnt] && !sh_eat[p_cnt] && sh_tv[p_cnt] &&
                 in_grid(cur_tail) && (owner_a == cur_own);
        if (last_p) state_n = ST_PUSH;
      end
      ST_PUSH: begin
        ram_wdata = cur_own;
        ram_we    = sh_alive[p_cnt] && !hit_acc[p_cnt] && (sh_tv[p_cnt] || sh_eat[p_cnt]);
        if (last_p) state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = (clr_pend || bus.clear_req) ? ST_CLEAR : ST_IDLE;
      end
      default: state_n = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_CLEAR;
      clr_addr     <= '0;
      p_cnt        <= '0;
      clr_pend     <= 1'b0;
      hit_acc      <= '0;
      hit_self_acc <= '0;
      hit_q        <= '0;
      hit_self_q   <= '0;
      done_q       <= 1'b0;
      tick_drop_q  <= 1'b0;
      q_ok_p1      <= 1'b0;
    end else begin
      state    <= state_n;
      clr_addr <= (state == ST_CLEAR && state_n == ST_CLEAR) ? clr_addr + 1'b1 : '0;

      if (state == ST_CHECK || state == ST_POP || state == ST_PUSH)
        p_cnt <= last_p ? '0 : p_cnt + 1'b1;
      else
        p_cnt <= '0;

      // A clear request outside IDLE waits until the current activity finishes.
      if (state != ST_CLEAR && state_n == ST_CLEAR) clr_pend <= 1'b0;
      else if (bus.clear_req && state != ST_IDLE)   clr_pend <= 1'b1;

      if (state == ST_CHECK) begin
        hit_acc[p_cnt]      <= hit_now;
        hit_self_acc[p_cnt] <= self_now;
      end

      if (accept) begin
        hit_q      <= '0;
        hit_self_q <= '0;
      end else if (state == ST_DONE) begin
        hit_q      <= hit_acc;
        hit_self_q <= hit_self_acc;
      end

      done_q      <= (state == ST_DONE);
      tick_drop_q <= bus.tick && !accept;
      q_ok_p1     <= in_grid({bus.q_x, bus.q_y}) && (state != ST_CLEAR);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sh_next  <= bus.ply_next_xy;
      sh_tail  <= bus.ply_tail_xy;
      sh_eat   <= bus.ply_eat;
      sh_tv    <= bus.ply_tail_valid;
      sh_alive <= bus.ply_alive;
    end
  end

  snake_occ_map_mp_occ_ram #(
    .DEPTH (CELLS),
    .AW    (AW),
    .IDW   (IDW)
  ) u_occ_ram (
    .clk     (clk),
    .we_a    (ram_we),
    .addr_a  (ram_addr),
    .wdata_a (ram_wdata),
    .rdata_a (rd_a),
    .addr_b  (cell_addr({bus.q_x, bus.q_y})),
    .rdata_b (rd_b)
  );

  // Query stage p1: RAM data qualified by the registered in-grid / not-clearing flag.
  logic [IDW-1:0] q_owner_p1;
  assign q_owner_p1    = q_ok_p1 ? rd_b : IDW'(OWNER_EMPTY);

  assign bus.q_owner   = q_owner_p1;
  assign bus.q_body_on = (q_owner_p1 != IDW'(OWNER_EMPTY));
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.hit       = hit_q;
  assign bus.hit_self  = hit_self_q;
  assign bus.tick_drop = tick_drop_q;
endmodule

// File: tb/tb_snake_occ_map_mp.sv
module tb_snake_occ_map_mp;
  import snake_occ_map_mp_pkg::*;

  localparam int XW     = DEF_XW;
  localparam int YW     = DEF_YW;
  localparam int GRID_W = DEF_GRID_W;
  localparam int GRID_H = DEF_GRID_H;
  localparam int NP     = 2;
  localparam int IDW    = 3;
  localparam int XYW    = XW + YW;
  localparam int CELLS  = GRID_W * GRID_H;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  snake_occ_map_mp_if #(.XW(XW), .YW(YW), .NP(NP), .IDW(IDW)) bus();

  snake_occ_map_mp #(
    .XW(XW), .YW(YW), .GRID_W(GRID_W), .GRID_H(GRID_H), .NP(NP), .IDW(IDW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [XYW-1:0] nxt0, nxt1, tl0, tl1;
    logic [1:0]     eat, tv, alive;
    logic [1:0]     exp_hit, exp_self;
    int             qx0, qy0, qe0, qx1, qy1, qe1;
  } vec_t;

  typedef struct {
    logic [1:0] hit;
    logic [1:0] hself;
  } exp_t;

  exp_t sb[$];
  vec_t vt[9];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input int x0, y0, tx0, ty0, x1, y1, tx1, ty1,
                              input logic [1:0] eat, tv, alive, eh, es,
                              input int qx0, qy0, qe0, qx1, qy1, qe1);
    vec_t v;
    v.nxt0 = xy_pack(XW'(x0), YW'(y0));
    v.tl0  = xy_pack(XW'(tx0), YW'(ty0));
    v.nxt1 = xy_pack(XW'(x1), YW'(y1));
    v.tl1  = xy_pack(XW'(tx1), YW'(ty1));
    v.eat = eat; v.tv = tv; v.alive = alive; v.exp_hit = eh; v.exp_self = es;
    v.qx0 = qx0; v.qy0 = qy0; v.qe0 = qe0; v.qx1 = qx1; v.qy1 = qy1; v.qe1 = qe1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at a later negedge.
  task automatic qchk(input int x, input int y, input int exp);
    bus.q_x = XW'(x);
    bus.q_y = YW'(y);
    @(negedge clk);
    chk($sformatf("q_owner(%0d,%0d)", x, y), 32'(bus.q_owner), 32'(exp));
    chk($sformatf("q_body_on(%0d,%0d)", x, y), 32'(bus.q_body_on), 32'(exp != 0));
  endtask

  task automatic wait_sweep(input string nm, input int exp_cycles);
    int n = 0;
    int dones = 0;
    while (bus.busy && n < 1500) begin
      @(negedge clk);
      n++;
      if (bus.done) dones++;
    end
    chk({nm, " busy cycles"}, 32'(n), 32'(exp_cycles));
    chk({nm, " no done"}, 32'(dones), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   lat = 0;
    bus.ply_next_xy    = {v.nxt1, v.nxt0};
    bus.ply_tail_xy    = {v.tl1, v.tl0};
    bus.ply_eat        = v.eat;
    bus.ply_tail_valid = v.tv;
    bus.ply_alive      = v.alive;
    bus.tick           = 1'b1;
    e.hit   = v.exp_hit;
    e.hself = v.exp_self;
    sb.push_back(e);
    @(negedge clk);
    bus.tick = 1'b0;
    chk($sformatf("v%0d busy", idx), 32'(bus.busy), 32'd1);
    chk($sformatf("v%0d tick_drop", idx), 32'(bus.tick_drop), 32'd0);
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(3 * NP + 1));
    e = sb.pop_front();
    chk($sformatf("v%0d hit", idx), 32'(bus.hit), 32'(e.hit));
    chk($sformatf("v%0d hit_self", idx), 32'(bus.hit_self), 32'(e.hself));
    @(negedge clk);
    chk($sformatf("v%0d hit held", idx), 32'(bus.hit), 32'(e.hit));
    chk($sformatf("v%0d done pulse", idx), 32'(bus.done), 32'd0);
    qchk(v.qx0, v.qy0, v.qe0);
    qchk(v.qx1, v.qy1, v.qe1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    //          P0 next   P0 tail   P1 next   P1 tail   eat    tv     alive  hit    self   queries
    vt[0] = mk(5, 5,    4, 5,    0, 0,     0, 0,    2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 5, 5, 1, 4, 5, 0);
    vt[1] = mk(0, 0,    0, 0,    10, 3,    0, 0,    2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 10, 3, 2, 5, 5, 1);
    vt[2] = mk(10, 3,   5, 5,    11, 3,    10, 3,   2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 10, 3, 1, 5, 5, 0);
    vt[3] = mk(11, 3,   10, 3,   12, 3,    11, 3,   2'b10, 2'b11, 2'b11, 2'b01, 2'b00, 10, 3, 0, 12, 3, 2);
    vt[4] = mk(0, 0,    0, 0,    40, 0,    11, 3,   2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 11, 3, 2, 40, 0, 0);
    vt[5] = mk(0, 0,    0, 0,    12, 3,    11, 3,   2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 11, 3, 0, 12, 3, 2);
`ifdef SNAKE_HEADHEAD_EN
    vt[6] = mk(8, 8,    0, 0,    8, 8,     0, 0,    2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 8, 8, 0, 12, 3, 2);
`else
    vt[6] = mk(8, 8,    0, 0,    8, 8,     0, 0,    2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 8, 8, 2, 12, 3, 2);
`endif
    vt[7] = mk(50, 31,  0, 0,    3, 3,     0, 0,    2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 3, 3, 0, 50, 31, 0);
    vt[8] = mk(0, 30,   0, 0,    39, 29,   0, 0,    2'b11, 2'b00, 2'b11, 2'b01, 2'b00, 39, 29, 2, 0, 29, 0);

    bus.clear_req      = 1'b0;
    bus.tick           = 1'b0;
    bus.ply_next_xy    = '0;
    bus.ply_tail_xy    = '0;
    bus.ply_eat        = '0;
    bus.ply_tail_valid = '0;
    bus.ply_alive      = '0;
    bus.q_x            = '0;
    bus.q_y            = '0;
    reset              = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd1);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset hit", 32'(bus.hit), 32'd0);
    chk("reset hit_self", 32'(bus.hit_self), 32'd0);
    chk("reset tick_drop", 32'(bus.tick_drop), 32'd0);
    chk("reset q_owner", 32'(bus.q_owner), 32'd0);
    chk("reset q_body_on", 32'(bus.q_body_on), 32'd0);
    reset = 1'b0;
    wait_sweep("power-on clear", CELLS);
    chk("idle busy", 32'(bus.busy), 32'd0);

    // Whole map reads empty after the sweep
    nz = 0;
    for (int y = 0; y < GRID_H; y++)
      for (int x = 0; x < GRID_W; x++) begin
        bus.q_x = XW'(x);
        bus.q_y = YW'(y);
        @(negedge clk);
        if (bus.q_owner !== '0) nz++;
      end
    chk("cleared map nonzero cells", 32'(nz), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // tick together with clear_req in IDLE: clear wins, tick dropped
    bus.ply_next_xy = {xy_pack(6'd1, 5'd1), xy_pack(6'd2, 5'd2)};
    bus.ply_eat     = 2'b11;
    bus.ply_alive   = 2'b11;
    bus.tick        = 1'b1;
    bus.clear_req   = 1'b1;
    @(negedge clk);
    bus.tick      = 1'b0;
    bus.clear_req = 1'b0;
    chk("tick+clear tick_drop", 32'(bus.tick_drop), 32'd1);
    chk("tick+clear busy", 32'(bus.busy), 32'd1);
    chk("tick+clear query in clear", 32'(bus.q_owner), 32'd0);
    @(negedge clk);
    chk("tick_drop single pulse", 32'(bus.tick_drop), 32'd0);
    wait_sweep("clear_req sweep", CELLS - 1);
    qchk(12, 3, 0);
    qchk(39, 29, 0);
    qchk(2, 2, 0);

    // Reset while in PUSH abandons the tick
    bus.ply_next_xy    = {xy_pack(6'd21, 5'd21), xy_pack(6'd20, 5'd20)};
    bus.ply_eat        = 2'b11;
    bus.ply_tail_valid = 2'b00;
    bus.ply_alive      = 2'b11;
    bus.tick           = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    repeat (2 * NP) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid-tick reset busy", 32'(bus.busy), 32'd1);
    chk("mid-tick reset done", 32'(bus.done), 32'd0);
    chk("mid-tick reset hit", 32'(bus.hit), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    chk("tick while clearing tick_drop", 32'(bus.tick_drop), 32'd1);
    wait_sweep("post-reset sweep", CELLS - 1);
    chk("post-reset tick_drop low", 32'(bus.tick_drop), 32'd0);
    qchk(20, 20, 0);
    qchk(21, 21, 0);
    qchk(8, 8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
